// File: rtl/aes192_pkg.sv
// Shared AES-192 types, state encoding and GF(2^8) helper for the key-schedule blocks.
// Pure declarations; no logic, no timing.
package aes192_pkg;

  localparam int AES192_NR = 12;
  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] block_t;
  typedef logic [31:0]          word_t;
  typedef logic [3:0]           round_idx_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_mixcol.sv
// InvMixColumns on one 32-bit column (byte 0 in bits 31:24).
// Purely combinational, zero latency, no flow control.
module aes_inv_mixcol
  import aes192_pkg::*;
(
  input  word_t col,
  output word_t res
);

  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin : mul_consts
    logic [7:0] a, x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a  = col[31-8*i -: 8];
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
  end

  // Circulant matrix rows: {0e 0b 0d 09} rotated right per output byte.
  assign res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
  assign res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
  assign res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
  assign res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/aes192dec_rkey_seq.sv
// Stores the AES-192 key schedule and streams it last-to-first, optionally InvMixColumns'd.
// Key appears one cycle after start, one per cycle under rk_ready; output regs hold while rk_ready=0.
module aes192dec_rkey_seq
  import aes192_pkg::*;
#(
  parameter int NUM_KEYS = AES192_NR + 1,
  parameter bit EQ_INV   = 1'b1
)
(
  input  logic         ap_clk,
  input  logic         ap_rst,
  input  logic         wr_valid,
  input  logic [3:0]   wr_idx,
  input  logic [127:0] wr_key,
  output logic         wr_ready,
  output logic         wr_err,
  input  logic         clear,
  input  logic         start,
  output logic         busy,
  output logic         keys_full,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         done
);

  localparam round_idx_t LAST_IDX = round_idx_t'(NUM_KEYS - 1);

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] bitmap_q, bitmap_d;
  block_t              key_mem [NUM_KEYS];
  round_idx_t          cnt_q;

  logic       wr_fire, wr_in_range, hs, start_ok, use_mix;
  round_idx_t sel_idx;
  block_t     sel_key, sel_mix, sel_out;

  // Reset gates wr_ready so every output reads 0 while ap_rst is held.
  assign wr_ready    = (state_q != STREAM) && !clear && !ap_rst;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_idx <= LAST_IDX);
  assign hs          = rk_valid && rk_ready;
  assign start_ok    = (state_q == READY) && start && !clear;
  assign busy        = (state_q == STREAM);
  assign keys_full   = &bitmap_q;
  assign rk_round    = cnt_q;

  always_comb begin
    bitmap_d = bitmap_q;
    state_d  = state_q;
    if (wr_fire && wr_in_range) bitmap_d[wr_idx] = 1'b1;
    if (clear) begin
      bitmap_d = '0;
      state_d  = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (&bitmap_d) state_d = READY;
        READY:   if (start) state_d = STREAM;
        STREAM:  if (hs && cnt_q == '0) state_d = READY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Key to load into the output register on this edge: top key on start, else the next lower one.
  assign sel_idx = start_ok ? LAST_IDX : ((cnt_q == '0) ? '0 : cnt_q - 4'd1);
  assign sel_key = key_mem[sel_idx];
  assign use_mix = EQ_INV && (sel_idx != '0) && (sel_idx != LAST_IDX);
  assign sel_out = use_mix ? sel_mix : sel_key;

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_inv_mixcol u_mix (
      .col (sel_key[127-32*c -: 32]),
      .res (sel_mix[127-32*c -: 32])
    );
  end

  always_ff @(posedge ap_clk) begin
    if (wr_fire && wr_in_range) key_mem[wr_idx] <= wr_key;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      bitmap_q <= '0;
      cnt_q    <= '0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_last  <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      wr_err   <= wr_fire && !wr_in_range;
      done     <= 1'b0;
      if (clear) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end else if (start_ok) begin
        rk_valid <= 1'b1;
        cnt_q    <= LAST_IDX;
        rk_data  <= sel_out;
        rk_last  <= (LAST_IDX == '0);
      end else if (state_q == STREAM && hs) begin
        if (cnt_q == '0) begin
          rk_valid <= 1'b0;
          rk_last  <= 1'b0;
          done     <= 1'b1;
        end else begin
          cnt_q   <= sel_idx;
          rk_data <= sel_out;
          rk_last <= (sel_idx == '0);
        end
      end
    end
  end

endmodule

// File: doc/aes192dec_rkey_seq.md
# aes192dec_rkey_seq

Round-key sequencer for the AES-192 decryption datapath: it stores the expanded key schedule and presents the round keys in descending order. The encryption round selects key N for round N; decryption consumes them last-to-first. Optionally it applies InvMixColumns to the middle keys so the downstream core can run the equivalent inverse cipher. It sits between the key-expansion block (the writer) and the decryption round pipeline (the reader).

## Interface

Parameters:
- NUM_KEYS, 13, number of round keys (Nr+1 for AES-192).
- EQ_INV, 1, apply InvMixColumns to keys 1..NUM_KEYS-2 on output; 0 passes keys through unchanged.

Ports:
- ap_clk  in  1  clock. One clock domain.
- ap_rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  key write strobe.
- wr_idx  in  4  round index to write.
- wr_key  in  128  round key; bit 127 is byte 0 of the state.
- wr_ready  out  1  write accepted this cycle.
- wr_err  out  1  one-cycle pulse when an out-of-range index is rejected.
- clear  in  1  invalidates all stored keys and aborts any stream.
- start  in  1  begins a descending key stream.
- busy  out  1  high while STREAM.
- keys_full  out  1  all NUM_KEYS slots are valid.
- rk_valid  out  1  output key valid.
- rk_ready  in  1  consumer accepts.
- rk_data  out  128  round key, transformed per EQ_INV.
- rk_round  out  4  index of the key on rk_data.
- rk_last  out  1  asserted with key 0.
- done  out  1  one-cycle pulse after the last handshake.

## Operation

- Storage: NUM_KEYS × 128-bit registers plus a valid bitmap.
- States:
  - EMPTY: bitmap not full.
  - READY: bitmap full.
  - STREAM: keys being presented.
- Writes:
  - wr_ready = (state != STREAM) && !clear.
  - A write with wr_valid && wr_ready && wr_idx < NUM_KEYS stores the key and sets its bitmap bit.
  - If wr_idx >= NUM_KEYS, nothing is stored and wr_err pulses on the next cycle.
  - Rewriting a slot is allowed and the bitmap stays full.
- Transitions:
  - EMPTY→READY when the bitmap becomes full.
  - READY→STREAM when start is high.
  - start in EMPTY or STREAM is ignored.
- STREAM:
  - The counter loads NUM_KEYS-1.
  - On each rk_valid && rk_ready the counter decrements.
  - After the handshake with rk_round=0 (rk_last=1): go to READY and pulse done.
- Transform: when EQ_INV=1 and 0 < idx < NUM_KEYS-1, rk_data = InvMixColumns(key[idx]), applied per 32-bit column. Otherwise rk_data = key[idx].
- clear:
  - Takes priority over every other input.
  - Next cycle: bitmap = 0, state = EMPTY, rk_valid = 0.
  - No done pulse is generated.
  - Simultaneous start and clear: clear wins.

## Timing

- Reset values: all outputs 0. Bitmap 0, state EMPTY, counter 0. Key registers are not reset.
- rk_data, rk_round, rk_valid and rk_last are registered.
- start sampled in cycle t → rk_valid=1 in cycle t+1 with rk_round=NUM_KEYS-1.
- Holding: when rk_ready=0, rk_data, rk_round and rk_last stay stable and rk_valid stays high.
- Throughput: with rk_ready held high, one key per cycle. NUM_KEYS handshakes occupy cycles t+1..t+NUM_KEYS; done pulses at t+NUM_KEYS+1.
- done cycle: state is READY, and start sampled then yields rk_valid the following cycle. This gives back-to-back passes with one bubble.
- busy = 1 from t+1 up to and including the last handshake cycle.
- keys_full reflects the bitmap with one-cycle latency after the completing write.

## Structure

- Shared package aes192_pkg:
  - AES192_NR=12, AES_BLK_W=128.
  - typedefs: block_t [127:0], word_t [31:0], round_idx_t [3:0].
  - State enum: EMPTY, READY, STREAM.
- Sub-module aes_inv_mixcol: purely combinational InvMixColumns on one 32-bit column, using GF(2^8) xtime multiplies by 0e/0b/0d/09. Instantiate it four times.

## Test plan

- Reset, then write key i = {16{i[7:0]}} for i=0..12 → keys_full=1. Pulse start with rk_ready=1 → rk_round 12,11,…,0 on consecutive cycles, rk_data = {16{idx}} (uniform columns are InvMixColumns fixed points), rk_last only on round 0, done one cycle later.
- EQ_INV=1, key 5 = 0x01000000_00000000_00000000_00000000 → stream shows rk_round=5 with rk_data 0x0e090d0b_00000000_00000000_00000000. The same value at key 12 or key 0 is output unchanged.
- Random rk_ready backpressure (≈50%) → no duplicate or skipped rounds, data stable while stalled, exactly 13 handshakes, one done pulse.
- Write only slots 0..11, then pulse start → no rk_valid, busy=0. Write slot 12, then start → stream begins.
- wr_idx=13 → wr_err pulse, keys_full unchanged. Write attempted during STREAM → wr_ready=0 and key unchanged.
- clear asserted mid-stream at rk_round=7 → next cycle rk_valid=0, keys_full=0, no done. Also async ap_rst mid-stream → all outputs 0 immediately.
